// File: rtl/linebuf_pkg.sv
// rtl/linebuf_pkg.sv - shared types and helpers for the line-buffer read sequencer
package linebuf_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // True when a WIDTH-bit counter can index every column and every row.
    function automatic bit width_ok(input int width, input int cols, input int rows);
        return ((64'd1 << width) >= 64'(max_i(cols, rows)));
    endfunction

    // Beats emitted per row; edge replication adds one replica at each end.
    function automatic int row_beats(input int cols, input bit border);
        return border ? cols + 2 : cols;
    endfunction

    function automatic int frame_beats(input int cols, input int rows, input bit border);
        return row_beats(cols, border) * rows;
    endfunction

endpackage

// File: rtl/wrap_counter.sv
// rtl/wrap_counter.sv - single-axis up-counter with enable, terminal count and wrap to zero
module wrap_counter #(
    parameter int WIDTH_P = 10,
    parameter int MAX_P   = 640
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    output logic [WIDTH_P-1:0] cnt_o,
    output logic               tc_o
);

    localparam logic [WIDTH_P-1:0] LAST_C = WIDTH_P'(MAX_P - 1);

    logic [WIDTH_P-1:0] cnt_q, cnt_d;

    // Advance on enable, folding back to zero after the last index.
    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = tc_o ? '0 : cnt_q + 1'b1;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o  = (cnt_q == LAST_C);
    assign cnt_o = cnt_q;

endmodule

// File: rtl/linebuf_rd_seq.sv
// rtl/linebuf_rd_seq.sv - raster-order column read address sequencer; LINEBUF_RD_BORDER_EN adds edge replication
module linebuf_rd_seq
    import linebuf_pkg::*;
#(
    parameter int WIDTH_P = 10,
    parameter int COLS_P  = 640,
    parameter int ROWS_P  = 480
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               ready_i,
    output logic               valid_o,
    output logic [WIDTH_P-1:0] addr_o,
    output logic [WIDTH_P-1:0] row_o,
    output logic               sol_o,
    output logic               eol_o,
    output logic               sof_o,
    output logic               eof_o,
    output logic               busy_o,
    output logic               done_o
);

    if (!width_ok(WIDTH_P, COLS_P, ROWS_P)) begin : g_bad_width
        $error("linebuf_rd_seq: WIDTH_P too small for COLS_P/ROWS_P");
    end

    localparam logic [WIDTH_P-1:0] LAST_COL_C = WIDTH_P'(COLS_P - 1);

    state_e             state_q, state_d;
    logic [WIDTH_P-1:0] col_cnt, row_cnt;
    logic               col_tc, row_tc;
    logic               col_en, row_en;
    logic               valid, hs;
    logic               sol, eol;

    assign valid = (state_q == RUN);
    assign hs    = valid & ready_i;

`ifdef LINEBUF_RD_BORDER_EN
    // phase_q marks the replica beat that repeats column 0 or the last column.
    logic phase_q, phase_d;
    logic at_edge;

    assign at_edge = (col_cnt == '0) | (col_cnt == LAST_COL_C);
    assign col_en  = hs & (phase_q | ~at_edge);
    assign sol     = (col_cnt == '0) & ~phase_q;
    assign eol     = (col_cnt == LAST_COL_C) & phase_q;

    // Enter the replica phase after a real edge beat, leave it after the replica.
    always_comb begin
        phase_d = phase_q;
        if (hs) begin
            phase_d = phase_q ? 1'b0 : at_edge;
        end
    end

    // Replica phase register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            phase_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
        end
    end
`else
    assign col_en = hs;
    assign sol    = (col_cnt == '0);
    assign eol    = (col_cnt == LAST_COL_C);
`endif

    assign row_en = col_en & col_tc;

    wrap_counter #(
        .WIDTH_P (WIDTH_P),
        .MAX_P   (COLS_P)
    ) u_col_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (col_en),
        .cnt_o (col_cnt),
        .tc_o  (col_tc)
    );

    wrap_counter #(
        .WIDTH_P (WIDTH_P),
        .MAX_P   (ROWS_P)
    ) u_row_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (row_en),
        .cnt_o (row_cnt),
        .tc_o  (row_tc)
    );

    // Frame control: start from IDLE, finish on the accepted last beat, one DONE cycle.
    // A start still held in DONE chains straight into the next frame.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_i) state_d = RUN;
            RUN:     if (hs && eol && row_tc) state_d = DONE;
            DONE:    state_d = start_i ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign valid_o = valid;
    assign busy_o  = valid;
    assign done_o  = (state_q == DONE);
    assign addr_o  = col_cnt;
    assign row_o   = row_cnt;
    assign sol_o   = valid & sol;
    assign eol_o   = valid & eol;
    assign sof_o   = valid & sol & (row_cnt == '0);
    assign eof_o   = valid & eol & row_tc;

endmodule
